// File: rtl/clk_window_scheduler.sv
// Phase counter and window programming for a bank of clock-generation
// comparators. Windows and period live in shadow registers and move to the
// active set together, either immediately while idle or on a counter wrap
// while running. This keeps generated clocks from glitching mid-period.

// Per-channel bound pair: a shadow copy written by software and an active copy
// seen by the comparator.
module cws_chan #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic             commit,
  input  logic [CNT_W-1:0] data,
  output logic [CNT_W-1:0] lower,
  output logic [CNT_W-1:0] upper
);
  logic [CNT_W-1:0] sh_lo, sh_hi;

  // Shadow capture. On a commit the active copy takes the post-write value,
  // so a write in the same cycle is included in that commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_lo <= '0;
      sh_hi <= '0;
      lower <= '0;
      upper <= '0;
    end else begin
      if (wr_lo) sh_lo <= data;
      if (wr_hi) sh_hi <= data;
      if (commit) begin
        lower <= wr_lo ? data : sh_lo;
        upper <= wr_hi ? data : sh_hi;
      end
    end
  end
endmodule

module clk_window_scheduler #(
  parameter int                NUM_CH         = 4,
  parameter int                CNT_W          = 32,
  parameter int                ADDR_W         = 4,
  parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [CNT_W-1:0]        cfg_data,
  input  logic                    cfg_commit,
  output logic                    commit_done,
  output logic                    cfg_err,
  output logic [CNT_W-1:0]        counter,
  output logic [NUM_CH*CNT_W-1:0] condition_lower,
  output logic [NUM_CH*CNT_W-1:0] condition_upper,
  output logic                    wrap,
  output logic                    busy
);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] MAX_A  = ADDR_W'(2*NUM_CH);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state;

  logic [CNT_W-1:0] per_act, per_sh, per_sh_nx, per_nx;
  logic acc, per_sel, per_wr, bad_wr, cmt_req, at_end, wrap_edge, apply;

  always_comb begin
    acc       = cfg_valid && cfg_ready;
    per_sel   = (cfg_addr == '0);
    bad_wr    = acc && ((cfg_addr > MAX_A) || (per_sel && cfg_data == '0));
    per_wr    = acc && per_sel && (cfg_data != '0);
    cmt_req   = cfg_commit && cfg_ready;
    // period_active is never zero, so the subtraction cannot underflow
    at_end    = (counter == per_act - ONE);
    wrap_edge = (state != IDLE) && at_end;
    // a commit taken on the wrap edge itself is applied right there
    apply     = ((state == IDLE) && cmt_req) ||
                (wrap_edge && ((state == PEND) || cmt_req));
    per_sh_nx = per_wr ? cfg_data : per_sh;
    per_nx    = apply ? per_sh_nx : per_act;
  end

  // Run/stop/pending control and the phase counter; stop only at a wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state   <= RUN;
          busy    <= 1'b1;
          counter <= (per_nx == ONE) ? '0 : ONE;
        end
        default: if (at_end) begin
          counter   <= '0;
          cfg_ready <= 1'b1;
          state     <= enable ? RUN : IDLE;
          busy      <= enable;
        end else begin
          counter <= counter + ONE;
          if (state == RUN && cmt_req) begin
            state     <= PEND;
            cfg_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Period shadow/active and the one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_sh      <= DEFAULT_PERIOD;
      per_act     <= DEFAULT_PERIOD;
      commit_done <= 1'b0;
      cfg_err     <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      per_sh      <= per_sh_nx;
      per_act     <= per_nx;
      commit_done <= apply;
      cfg_err     <= bad_wr;
      wrap        <= wrap_edge;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [ADDR_W-1:0] A_LO = ADDR_W'(2*k+1);
    localparam logic [ADDR_W-1:0] A_HI = ADDR_W'(2*k+2);
    cws_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .wr_lo  (acc && cfg_addr == A_LO),
      .wr_hi  (acc && cfg_addr == A_HI),
      .commit (apply),
      .data   (cfg_data),
      .lower  (condition_lower[k*CNT_W +: CNT_W]),
      .upper  (condition_upper[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_clk_window_scheduler.sv
// Randomized and directed checking of clk_window_scheduler against a
// behavioural model of the register file and phase counter.
module tb_clk_window_scheduler;
  localparam int N = 4, W = 32, AW = 4, DP = 4;

  logic clk = 0, reset = 1, enable = 0, cfg_valid = 0, cfg_commit = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic cfg_ready, commit_done, cfg_err, wrap, busy;
  logic [W-1:0] counter;
  logic [N*W-1:0] condition_lower, condition_upper;

  clk_window_scheduler #(.NUM_CH(N), .CNT_W(W), .ADDR_W(AW), .DEFAULT_PERIOD(DP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .commit_done(commit_done), .cfg_err(cfg_err),
    .counter(counter), .condition_lower(condition_lower),
    .condition_upper(condition_upper), .wrap(wrap), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // model: register file indexed by config address (0 = period)
  int unsigned sh[2*N+1], act[2*N+1];
  int unsigned m_cnt;
  bit m_run, m_pend, m_wrap, m_done, m_err;

  task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (sh[i]) sh[i] = 0;
    sh[0] = DP;
    act = sh;
    m_cnt = 0; m_run = 0; m_pend = 0; m_wrap = 0; m_done = 0; m_err = 0;
  endtask

  // one clock of the programmer-visible behaviour
  task automatic model_step(input bit v, input int unsigned a, input int unsigned d,
                            input bit c, input bit en);
    bit ready, cm;
    ready  = !m_pend;
    m_wrap = 0; m_done = 0;
    m_err  = v && ready && (a > 2*N || (a == 0 && d == 0));
    if (v && ready && !m_err) sh[a] = d;
    cm = c && ready;
    if (!m_run) begin
      if (cm) begin act = sh; m_done = 1; end
      if (en) begin m_run = 1; m_cnt = (act[0] == 1) ? 0 : 1; end
    end else if (m_cnt == act[0] - 1) begin
      m_wrap = 1;
      if (m_pend || cm) begin act = sh; m_done = 1; m_pend = 0; end
      m_cnt = 0;
      if (!en) m_run = 0;
    end else begin
      m_cnt++;
      if (cm) m_pend = 1;
    end
  endtask

  task automatic compare_all();
    logic [N*W-1:0] lo, hi;
    for (int k = 0; k < N; k++) begin
      lo[k*W +: W] = act[2*k+1];
      hi[k*W +: W] = act[2*k+2];
    end
    chk("counter", counter, m_cnt);
    chk("wrap", wrap, m_wrap);
    chk("busy", busy, m_run);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("commit_done", commit_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    chk("lower", condition_lower, lo);
    chk("upper", condition_upper, hi);
  endtask

  // drive at the negedge, let one posedge pass, compare at the next negedge
  task automatic cycle(input bit v, input int unsigned a, input int unsigned d,
                       input bit c, input bit en);
    cfg_valid = v; cfg_addr = AW'(a); cfg_data = d; cfg_commit = c; enable = en;
    model_step(v, a, d, c, en);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int unsigned seq1[5] = '{1, 2, 3, 0, 1};
    int unsigned a, d;
    // reset
    #2 reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_ready", cfg_ready, 1);
    reset = 1;
    cycle(0, 0, 0, 0, 0);

    // free-running with the default period
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 1);
      chk("tp1_seq", counter, seq1[i]);
    end
    chk("tp1_busy", busy, 1);

    // stop request mid-period runs to the wrap
    cycle(0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0);
    chk("tp5_wrap", wrap, 1);
    chk("tp5_busy", busy, 0);
    cycle(0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0);
    chk("tp5_hold", counter, 0);

    // idle write + commit applies next cycle
    cycle(1, 1, 0, 0, 0);
    cycle(1, 2, 2, 1, 0);
    chk("tp2_upper", condition_upper[W-1:0], 2);
    chk("tp2_done", commit_done, 1);
    cycle(0, 0, 0, 0, 0);
    chk("tp2_done_end", commit_done, 0);

    // period change while running waits for the wrap
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 6, 1, 1);
    chk("tp3_ready", cfg_ready, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("tp3_done", commit_done, 1);
    chk("tp3_wrap", wrap, 1);
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 0, 0, 0, 1);
      chk("tp3_seq", counter, i);
    end

    // rejected writes
    cycle(1, 15, 5, 0, 1);
    chk("tp4_err_addr", cfg_err, 1);
    cycle(1, 0, 0, 0, 1);
    chk("tp4_err_zero", cfg_err, 1);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    chk("tp4_period", counter, 5);

    // reset while a commit is pending
    cycle(1, 1, 7, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    chk("tp6_pend", cfg_ready, 0);
    reset = 0;
    #1;
    chk("tp6_cnt", counter, 0);
    chk("tp6_busy", busy, 0);
    chk("tp6_ready", cfg_ready, 1);
    chk("tp6_lower", condition_lower, '0);
    model_reset();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, i > 0);
    chk("tp6_no_done", commit_done, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, 11);
      d = (a == 0) ? $urandom_range(0, 6) : $urandom;
      cycle($urandom_range(0, 1), a, d, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_window_scheduler.md
Name: clk_window_scheduler

Overview:
- Owns the shared phase counter and programs the lower/upper windows for a bank of NUM_CH clock-generation window comparators.
- Each comparator drives low while lower < counter <= upper.
- Software loads new windows and the period into shadow registers. They become active together on a counter wrap, so generated clocks never glitch mid-period.
- Sits between the config bus and the comparator bank in the clock-generation subsystem.

Parameters:
NUM_CH, 4, number of comparator channels served
CNT_W, 32, counter and window width
ADDR_W, 4, config address width (2*NUM_CH+1 <= 2**ADDR_W)
DEFAULT_PERIOD, 4, active and shadow period after reset (nonzero)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run request for the phase counter
cfg_valid  in  1  config write strobe
cfg_ready  out  1  write/commit accepted when high
cfg_addr  in  ADDR_W  0=period, 2k+1=lower ch k, 2k+2=upper ch k
cfg_data  in  CNT_W  write data
cfg_commit  in  1  request shadow->active transfer
commit_done  out  1  1-cycle pulse when active registers are updated
cfg_err  out  1  1-cycle pulse on rejected write
counter  out  CNT_W  shared phase counter to comparators
condition_lower  out  NUM_CH*CNT_W  active lower bounds, ch k at [k*CNT_W +: CNT_W]
condition_upper  out  NUM_CH*CNT_W  active upper bounds, same packing
wrap  out  1  high during cycles where counter==0 following a wrap
busy  out  1  high in RUN or PEND

Behaviour:
- Reset (reset low, async) sets:
  - counter=0.
  - Active and shadow period=DEFAULT_PERIOD.
  - All active and shadow bounds=0, so windows are empty and comparator outputs are high.
  - State IDLE, cfg_ready=1, commit_done=0, cfg_err=0, wrap=0, busy=0.
  - Any pending commit is discarded.
- All other logic is registered on posedge clk.
- FSM states: IDLE, RUN, PEND.
  - IDLE: counter held at 0. If enable=1, go to RUN; counter reads 1 on the following edge.
  - RUN / PEND counting:
    - If counter==period_active-1, the next counter value is 0 and wrap=1 in that cycle.
    - Otherwise the counter increments by 1.
    - The counter never exceeds period_active-1 and never overflows CNT_W.
  - Stopping: enable=0 is only acted on at the wrap edge. At that edge, go to IDLE with counter=0. A partial period is never truncated.
  - RUN -> PEND when a commit is accepted.
  - PEND -> RUN (or IDLE if enable=0) at the wrap edge.
- Config write:
  - Accepted when cfg_valid && cfg_ready.
  - The shadow register updates on that edge.
  - Invalid address (> 2*NUM_CH) or period write of 0: shadow unchanged, cfg_err pulses the next cycle.
  - Upper < lower is legal; it gives an empty window.
- Commit:
  - Sampled only when cfg_ready=1.
  - In IDLE, all shadows copy to active on the next edge; commit_done pulses in that same cycle.
  - In RUN, go to PEND. cfg_ready=0 throughout PEND, so writes and commits stall.
  - At the wrap edge (counter period_active-1 -> 0), all shadows copy to active atomically and commit_done=1 alongside wrap=1. The new period governs the period that starts there.
- Simultaneous write and commit in the same cycle: the write lands in shadow first and is included in the commit.
- cfg_ready=1 in IDLE and RUN, 0 in PEND.
- Outputs change only at the defined edges; active bounds never change except on a commit edge.

Test Plan:
- Reset, enable=1, DEFAULT_PERIOD=4 -> counter 0,1,2,3,0,1…; wrap high on each return to 0; busy=1.
- In IDLE write addr1=0, addr2=2, commit -> next cycle condition_lower[ch0]=0, condition_upper[ch0]=2, commit_done one pulse.
- While RUN at counter=1 (period 4): write period=6, commit -> cfg_ready=0; active period stays 4 until counter 3->0; commit_done coincides with wrap; then sequence 0..5.
- Write addr=15 or period=0 -> cfg_err pulse next cycle; shadow readback via subsequent commit shows old values.
- Drop enable at counter=1 -> counter continues to 3, returns 0, state IDLE, busy=0, counter held 0.
- Assert reset low mid-PEND -> all outputs immediately at reset values; after release, commit_done never pulses for the discarded commit.
